gt_rx_comma_align: RTL and testbench
====================================

GT_RX_COMMA_ALIGN -- requirements
Module: gt_rx_comma_align

Interface
REQ-001 SHALL have parameter P_COMMA, default 8'hBC, the K28.5 comma byte value.
REQ-002 SHALL have parameter P_LOCK_CNT, default 4, the number of same-lane commas required to lock (legal range 1..15).
REQ-003 SHALL have parameter P_LOSS_CNT, default 4, the number of consecutive wrong-lane commas that drop lock (legal range 1..15).
REQ-004 SHALL have port i_rx_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port i_rx_rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port i_rx_ByteAlign, input, 1 bit: GT byte-alignment status.
REQ-007 SHALL have port i_gt_rx_data, input, 32 bits: raw GT word; lane k occupies bits [8k+7:8k].
REQ-008 SHALL have port i_gt_rx_char, input, 4 bits: K-flag per lane.
REQ-009 SHALL have port o_align_data, output, 32 bits: word-aligned data to PHY rx, with the comma in lane 3.
REQ-010 SHALL have port o_align_char, output, 4 bits: K-flags aligned identically to o_align_data.
REQ-011 SHALL have port o_align_valid, output, 1 bit: aligned word is meaningful.
REQ-012 SHALL have port o_lock, output, 1 bit: high while in state LOCK.
REQ-013 SHALL have port o_lane_offset, output, 2 bits: the captured comma lane k.

Function
REQ-014 SHALL detect a comma in lane k when data byte k == P_COMMA and char[k] == 1.
- Words with no comma byte are neutral.
- Words with two or more comma bytes are neutral; no counter changes.
REQ-015 SHALL register every input word into r_prev each cycle and form cat = {r_prev, current input} (64 bits).
- Aligned data = cat[8(k+1)+31 : 8(k+1)].
- Aligned char = the matching 4-bit slice of {prev_char, cur_char}.
REQ-016 SHALL register the aligned outputs.
- Fixed latency: 2 cycles from input sample to output.
- k = 3 yields the input delayed by 2 cycles, unchanged.
REQ-017 SHALL implement state machine UNLOCK -> CHECK -> LOCK, with a 4-bit counter.
REQ-018 In UNLOCK, a single-lane comma SHALL capture k, set cnt = 1, and go to CHECK; if P_LOCK_CNT == 1, it goes directly to LOCK.
REQ-019 In CHECK:
- A comma in lane k SHALL increment cnt.
- Reaching P_LOCK_CNT SHALL enter LOCK at the next edge.
- A comma in another lane SHALL recapture k and set cnt = 1.
REQ-020 In LOCK, k SHALL be frozen.
- Each wrong-lane comma increments a miss counter.
- A correct-lane comma clears the miss counter.
- Reaching P_LOSS_CNT misses SHALL go to UNLOCK at the next edge and clear both counters.
REQ-021 When i_rx_ByteAlign == 0, the block SHALL force UNLOCK at the next edge, clear the counters, and ignore that cycle's word; this has priority over all other transitions.
REQ-022 o_align_valid SHALL be registered as (state == LOCK).
- The comma word that completes lock is therefore the first valid output, with P_COMMA in lane 3 and char[3] = 1.
REQ-023 o_lock SHALL equal (state == LOCK), with no extra delay.
REQ-024 o_align_data and o_align_char SHALL be driven to 0 whenever o_align_valid is 0.
REQ-025 o_lane_offset SHALL update on each capture of k and hold its value otherwise.

Reset
REQ-026 While i_rx_rst == 0 at a clock edge, all of the following SHALL be cleared: state = UNLOCK, counters = 0, r_prev = 0, all outputs = 0.
REQ-027 Reset asserted mid-frame or while in LOCK SHALL take effect at that edge; after release, relock requires P_LOCK_CNT fresh commas.

Verification
REQ-028 Reset: hold i_rx_rst = 0 for 3 cycles with random input -> all outputs 0, o_lock = 0.
REQ-029 Lock in lane 1: alternate 32'h1122BC33 / char 4'b0010 with 32'h44556677 / char 0, four commas total.
- o_lock rises one edge after the 4th comma is sampled.
- o_lane_offset = 1.
- First valid output is 32'hBC334455 with char 4'b1000.
REQ-030 Lane 3: 4x 32'hBC000000 / char 4'b1000, then 32'hA5A5A5A5 / char 0.
- After lock, output equals input delayed by exactly 2 cycles.
- o_lane_offset = 3.
REQ-031 Lane change before lock: 2 commas in lane 1, then commas in lane 2 (32'h00BC0000 / char 4'b0100).
- No lock until the 4th lane-2 comma.
- o_lane_offset = 2.
REQ-032 Loss of lock:
- Locked in lane 1, 3 lane-0 commas then 1 lane-1 comma -> o_lock stays 1.
- Then 4 consecutive lane-0 commas -> o_lock falls one edge after the 4th, and o_align_valid falls one edge later.
REQ-033 Forced unlock: while locked, drive i_rx_ByteAlign = 0 for 1 cycle.
- o_lock = 0 at the next edge.
- Relock after 4 commas.
- Repeat with i_rx_rst = 0 for 1 cycle instead -> same response.

Source files
------------

// File: rtl/gt_rx_comma_align.sv
// gt_rx_comma_align: finds the K28.5 comma lane, locks on it and rotates GT words so the comma lands in lane 3
module gt_rx_comma_align #(
  parameter logic [7:0] P_COMMA    = 8'hBC,
  parameter int         P_LOCK_CNT = 4,
  parameter int         P_LOSS_CNT = 4
) (
  input  logic        i_rx_clk,
  input  logic        i_rx_rst,
  input  logic        i_rx_ByteAlign,
  input  logic [31:0] i_gt_rx_data,
  input  logic [3:0]  i_gt_rx_char,
  output logic [31:0] o_align_data,
  output logic [3:0]  o_align_char,
  output logic        o_align_valid,
  output logic        o_lock,
  output logic [1:0]  o_lane_offset
);
  typedef enum logic [1:0] {UNLOCK, CHECK, LOCK} state_t;
  localparam logic [3:0] LOCK_N = 4'(P_LOCK_CNT);
  localparam logic [3:0] LOSS_N = 4'(P_LOSS_CNT);
  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx, miss, miss_nx;
  logic [1:0]  lane_nx, hit_lane;
  logic [3:0]  hit;
  logic        single;
  logic [31:0] prev_data;
  logic [3:0]  prev_char;
  logic [63:0] cat_data;
  logic [7:0]  cat_char;
  logic [31:0] sel_data;
  logic [3:0]  sel_char;
  for (genvar i = 0; i < 4; i++) begin : g_hit
    assign hit[i] = (i_gt_rx_data[8*i +: 8] == P_COMMA) && i_gt_rx_char[i];
  end
  assign single   = $onehot(hit);
  assign hit_lane = hit[3] ? 2'd3 : hit[2] ? 2'd2 : hit[1] ? 2'd1 : 2'd0;
  assign cat_data = {prev_data, i_gt_rx_data};
  assign cat_char = {prev_char, i_gt_rx_char};
  assign sel_data = cat_data[8*o_lane_offset + 8 +: 32];
  assign sel_char = cat_char[o_lane_offset + 1 +: 4];
  assign o_lock   = state == LOCK;
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    miss_nx  = miss;
    lane_nx  = o_lane_offset;
    if (!i_rx_ByteAlign) begin
      state_nx = UNLOCK;
      cnt_nx   = '0;
      miss_nx  = '0;
    end else if (single) begin
      if (state == LOCK) begin
        miss_nx = hit_lane == o_lane_offset ? 4'd0 : miss + 4'd1;
        if (hit_lane != o_lane_offset && miss + 4'd1 == LOSS_N) begin
          state_nx = UNLOCK;
          cnt_nx   = '0;
          miss_nx  = '0;
        end
      end else if (state == CHECK && hit_lane == o_lane_offset) begin
        cnt_nx   = cnt + 4'd1;
        state_nx = cnt + 4'd1 == LOCK_N ? LOCK : CHECK;
      end else begin
        lane_nx  = hit_lane;
        cnt_nx   = 4'd1;
        state_nx = LOCK_N == 4'd1 ? LOCK : CHECK;
      end
    end
  end
  always_ff @(posedge i_rx_clk) begin
    if (!i_rx_rst) begin
      state         <= UNLOCK;
      cnt           <= '0;
      miss          <= '0;
      o_lane_offset <= '0;
      prev_data     <= '0;
      prev_char     <= '0;
      o_align_data  <= '0;
      o_align_char  <= '0;
      o_align_valid <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      miss          <= miss_nx;
      o_lane_offset <= lane_nx;
      prev_data     <= i_gt_rx_data;
      prev_char     <= i_gt_rx_char;
      o_align_data  <= state == LOCK ? sel_data : '0;
      o_align_char  <= state == LOCK ? sel_char : '0;
      o_align_valid <= state == LOCK;
    end
  end
endmodule

// File: tb/tb_gt_rx_comma_align.sv
// tb_gt_rx_comma_align: directed checks of comma lock, alignment, loss and forced unlock
module tb_gt_rx_comma_align;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ba = 1'b1;
  logic [31:0] din = '0;
  logic [3:0]  kin = '0;
  logic [31:0] o_align_data;
  logic [3:0]  o_align_char;
  logic        o_align_valid, o_lock;
  logic [1:0]  o_lane_offset;
  int          n_cmp = 0;
  int          n_err = 0;
  localparam logic [31:0] C1_D = 32'h1122BC33;
  localparam logic [3:0]  C1_K = 4'b0010;
  localparam logic [31:0] N_D  = 32'h44556677;
  localparam logic [31:0] C0_D = 32'h000000BC;
  localparam logic [3:0]  C0_K = 4'b0001;
  gt_rx_comma_align dut (
    .i_rx_clk(clk),
    .i_rx_rst(rst_n),
    .i_rx_ByteAlign(ba),
    .i_gt_rx_data(din),
    .i_gt_rx_char(kin),
    .o_align_data(o_align_data),
    .o_align_char(o_align_char),
    .o_align_valid(o_align_valid),
    .o_lock(o_lock),
    .o_lane_offset(o_lane_offset)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [31:0] d, input logic [3:0] k, input logic a, input logic r);
    @(negedge clk);
    din = d;
    kin = k;
    ba = a;
    rst_n = r;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      step($urandom, 4'($urandom), 1'b1, 1'b0);
      n_cmp++;
      if (o_align_data !== 32'h0 || o_align_char !== 4'h0 || o_align_valid !== 1'b0 || o_lock !== 1'b0 || o_lane_offset !== 2'd0) begin
        n_err++;
        $display("FAIL reset[%0d]: data=%h char=%h valid=%b lock=%b off=%0d, required all 0", i, o_align_data, o_align_char, o_align_valid, o_lock, o_lane_offset);
      end
    end
  endtask
  task automatic test_lane1;
    step(32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(C1_D, C1_K, 1'b1, 1'b1);
      n_cmp++;
      if (o_lock !== (i == 3)) begin
        n_err++;
        $display("FAIL lane1_lock[%0d]: got %b required %b", i, o_lock, i == 3);
      end
      if (i < 3) step(N_D, 4'h0, 1'b1, 1'b1);
    end
    n_cmp++;
    if (o_lane_offset !== 2'd1 || o_align_valid !== 1'b0) begin
      n_err++;
      $display("FAIL lane1_offset: off=%0d valid=%b required off=1 valid=0", o_lane_offset, o_align_valid);
    end
    step(N_D, 4'h0, 1'b1, 1'b1);
    n_cmp++;
    if (o_align_valid !== 1'b1 || o_align_data !== 32'hBC334455 || o_align_char !== 4'b1000) begin
      n_err++;
      $display("FAIL lane1_first: valid=%b data=%h char=%b required 1 BC334455 1000", o_align_valid, o_align_data, o_align_char);
    end
    step(C1_D, C1_K, 1'b1, 1'b1);
    n_cmp++;
    if (o_align_data !== 32'h66771122 || o_align_char !== 4'b0000) begin
      n_err++;
      $display("FAIL lane1_second: data=%h char=%b required 66771122 0000", o_align_data, o_align_char);
    end
  endtask
  task automatic test_lane3;
    step(32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(32'hBC000000, 4'b1000, 1'b1, 1'b1);
    n_cmp++;
    if (o_lock !== 1'b1 || o_lane_offset !== 2'd3) begin
      n_err++;
      $display("FAIL lane3_lock: lock=%b off=%0d required 1 3", o_lock, o_lane_offset);
    end
    step(32'hA5A5A5A5, 4'h0, 1'b1, 1'b1);
    n_cmp++;
    if (o_align_valid !== 1'b1 || o_align_data !== 32'hBC000000 || o_align_char !== 4'b1000) begin
      n_err++;
      $display("FAIL lane3_first: valid=%b data=%h char=%b required 1 BC000000 1000", o_align_valid, o_align_data, o_align_char);
    end
    step(32'h12345678, 4'h0, 1'b1, 1'b1);
    n_cmp++;
    if (o_align_data !== 32'hA5A5A5A5 || o_align_char !== 4'h0) begin
      n_err++;
      $display("FAIL lane3_delay1: data=%h char=%b required A5A5A5A5 0000", o_align_data, o_align_char);
    end
    step(32'h0, 4'h0, 1'b1, 1'b1);
    n_cmp++;
    if (o_align_data !== 32'h12345678) begin
      n_err++;
      $display("FAIL lane3_delay2: data=%h required 12345678", o_align_data);
    end
  endtask
  task automatic test_lane_change;
    step(32'h0, 4'h0, 1'b1, 1'b0);
    step(C1_D, C1_K, 1'b1, 1'b1);
    step(C1_D, C1_K, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(32'h00BC0000, 4'b0100, 1'b1, 1'b1);
      n_cmp++;
      if (o_lock !== (i == 3) || o_lane_offset !== 2'd2) begin
        n_err++;
        $display("FAIL change[%0d]: lock=%b off=%0d required %b 2", i, o_lock, o_lane_offset, i == 3);
      end
    end
  endtask
  task automatic test_loss;
    step(32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(C1_D, C1_K, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(C0_D, C0_K, 1'b1, 1'b1);
    step(C1_D, C1_K, 1'b1, 1'b1);
    n_cmp++;
    if (o_lock !== 1'b1) begin
      n_err++;
      $display("FAIL loss_hold: lock=%b required 1", o_lock);
    end
    for (int i = 0; i < 4; i++) begin
      step(C0_D, C0_K, 1'b1, 1'b1);
      n_cmp++;
      if (o_lock !== (i != 3)) begin
        n_err++;
        $display("FAIL loss_miss[%0d]: lock=%b required %b", i, o_lock, i != 3);
      end
    end
    n_cmp++;
    if (o_align_valid !== 1'b1) begin
      n_err++;
      $display("FAIL loss_valid_lag: valid=%b required 1", o_align_valid);
    end
    step(N_D, 4'h0, 1'b1, 1'b1);
    n_cmp++;
    if (o_align_valid !== 1'b0 || o_align_data !== 32'h0 || o_align_char !== 4'h0) begin
      n_err++;
      $display("FAIL loss_valid_off: valid=%b data=%h char=%b required 0 0 0", o_align_valid, o_align_data, o_align_char);
    end
  endtask
  task automatic test_force_unlock;
    step(32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(C1_D, C1_K, 1'b1, 1'b1);
    step(C1_D, C1_K, 1'b0, 1'b1);
    n_cmp++;
    if (o_lock !== 1'b0) begin
      n_err++;
      $display("FAIL bytealign_drop: lock=%b required 0", o_lock);
    end
    for (int i = 0; i < 4; i++) begin
      step(C1_D, C1_K, 1'b1, 1'b1);
      n_cmp++;
      if (o_lock !== (i == 3)) begin
        n_err++;
        $display("FAIL bytealign_relock[%0d]: lock=%b required %b", i, o_lock, i == 3);
      end
    end
    step(C1_D, C1_K, 1'b1, 1'b0);
    n_cmp++;
    if (o_lock !== 1'b0 || o_align_valid !== 1'b0 || o_align_data !== 32'h0 || o_lane_offset !== 2'd0) begin
      n_err++;
      $display("FAIL rst_drop: lock=%b valid=%b data=%h off=%0d required 0 0 0 0", o_lock, o_align_valid, o_align_data, o_lane_offset);
    end
    for (int i = 0; i < 4; i++) begin
      step(C1_D, C1_K, 1'b1, 1'b1);
      n_cmp++;
      if (o_lock !== (i == 3)) begin
        n_err++;
        $display("FAIL rst_relock[%0d]: lock=%b required %b", i, o_lock, i == 3);
      end
    end
    n_cmp++;
    if (o_lane_offset !== 2'd1) begin
      n_err++;
      $display("FAIL rst_relock_off: off=%0d required 1", o_lane_offset);
    end
  endtask
  initial begin
    test_reset;
    test_lane1;
    test_lane3;
    test_lane_change;
    test_loss;
    test_force_unlock;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
